// File: rtl/player_move_arbiter.sv
// player_move_arbiter: once-per-frame round-robin owner of the shared step path; `PLAYER_ARB_HOLD_LIMIT_EN` forces a handoff after MAX_HOLD frames
module player_move_arbiter #(
  parameter int unsigned MAX_HOLD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_tick,
  input  logic       req1_left,
  input  logic       req1_right,
  input  logic       req2_left,
  input  logic       req2_right,
  output logic [1:0] grant,
  output logic       step_left,
  output logic       step_right,
  output logic       step_id,
  output logic [7:0] hold_cnt
);
  localparam logic [1:0] IDLE = 2'd0, GRANT1 = 2'd1, GRANT2 = 2'd2, SWITCH = 2'd3;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end
  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       v_tick_old_q;
  logic       step_left_q, step_left_d, step_right_q, step_right_d, step_id_q, step_id_d;
  logic       frame_edge, r1, r2, own, r_own, handoff, next_grant, next_p2;
  logic [1:0] dir;
  assign frame_edge = v_tick & ~v_tick_old_q;
  assign r1 = req1_left | req1_right;
  assign r2 = req2_left | req2_right;
  assign own = state_q == GRANT2;
  assign r_own = own ? r2 : r1;
`ifdef PLAYER_ARB_HOLD_LIMIT_EN
  assign handoff = hold_cnt_q >= 8'(MAX_HOLD) && (own ? r1 : r2);
`else
  assign handoff = 1'b0;
`endif
  // last_owner_q = 1 means player 2 owned last, so player 1 wins ties
  always_comb begin
    state_d = state_q;
    last_owner_d = last_owner_q;
    if (frame_edge) begin
      unique case (state_q)
        IDLE: state_d = (r1 && r2) ? (last_owner_q ? GRANT1 : GRANT2) : r1 ? GRANT1 : r2 ? GRANT2 : IDLE;
        SWITCH: state_d = (last_owner_q ? r1 : r2) ? (last_owner_q ? GRANT1 : GRANT2) : IDLE;
        default: begin
          state_d = !r_own ? IDLE : handoff ? SWITCH : state_q;
          last_owner_d = (!r_own || handoff) ? own : last_owner_q;
        end
      endcase
    end
  end
  assign next_grant = state_d == GRANT1 || state_d == GRANT2;
  assign next_p2 = state_d == GRANT2;
  assign dir = next_p2 ? {req2_left, req2_right} : {req1_left, req1_right};
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    step_left_d = 1'b0;
    step_right_d = 1'b0;
    step_id_d = step_id_q;
    if (frame_edge) begin
      hold_cnt_d = !next_grant ? 8'd0 : (state_d != state_q) ? 8'd1 : hold_cnt_q + {7'd0, hold_cnt_q != 8'hff};
      step_left_d = next_grant && dir == 2'b10;
      step_right_d = next_grant && dir == 2'b01;
      step_id_d = (next_grant && ^dir) ? next_p2 : step_id_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q <= 8'd0;
      v_tick_old_q <= 1'b0;
      step_left_q <= 1'b0;
      step_right_q <= 1'b0;
      step_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q <= hold_cnt_d;
      v_tick_old_q <= v_tick;
      step_left_q <= step_left_d;
      step_right_q <= step_right_d;
      step_id_q <= step_id_d;
    end
  end
  assign grant = {state_q == GRANT2, state_q == GRANT1};
  assign step_left = step_left_q;
  assign step_right = step_right_q;
  assign step_id = step_id_q;
  assign hold_cnt = hold_cnt_q;
endmodule

// File: tb/tb_player_move_arbiter.sv
// tb_player_move_arbiter: directed checks of grant, step strobes and hold count
module tb_player_move_arbiter;
  logic clk, rst, v_tick, req1_left, req1_right, req2_left, req2_right;
  logic [1:0] grant;
  logic step_left, step_right, step_id;
  logic [7:0] hold_cnt;
  logic [1:0] g;
  logic sl, sr, sid, clr;
  logic [7:0] h;
  int tests = 0, fails = 0, pulses;
  player_move_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .v_tick(v_tick),
    .req1_left(req1_left), .req1_right(req1_right),
    .req2_left(req2_left), .req2_right(req2_right),
    .grant(grant), .step_left(step_left), .step_right(step_right),
    .step_id(step_id), .hold_cnt(hold_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic frame;
    @(negedge clk) v_tick = 1'b1;
    @(negedge clk);
    g = grant; sl = step_left; sr = step_right; sid = step_id; h = hold_cnt;
    v_tick = 1'b0;
    @(negedge clk);
    clr = step_left | step_right;
  endtask
  task automatic chk_frame(input string tag, input logic [1:0] eg, input logic esl, input logic esr,
                           input logic esid, input logic [7:0] eh);
    chk({tag, ".grant"}, 32'(g), 32'(eg));
    chk({tag, ".step_left"}, 32'(sl), 32'(esl));
    chk({tag, ".step_right"}, 32'(sr), 32'(esr));
    chk({tag, ".hold_cnt"}, 32'(h), 32'(eh));
    chk({tag, ".strobe_clear"}, 32'(clr), 32'd0);
    if (esl || esr) chk({tag, ".step_id"}, 32'(sid), 32'(esid));
  endtask
  initial begin
    rst = 1'b1; v_tick = 1'b0;
    req1_left = 1'b0; req1_right = 1'b0; req2_left = 1'b0; req2_right = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.grant", 32'(grant), 32'd0);
    chk("reset.steps", 32'({step_left, step_right}), 32'd0);
    chk("reset.step_id", 32'(step_id), 32'd0);
    chk("reset.hold_cnt", 32'(hold_cnt), 32'd0);
    rst = 1'b0;
    req1_right = 1'b1;
    frame(); chk_frame("p1_right_f1", 2'b01, 1'b0, 1'b1, 1'b0, 8'd1);
    frame(); chk_frame("p1_right_f2", 2'b01, 1'b0, 1'b1, 1'b0, 8'd2);
    frame(); chk_frame("p1_right_f3", 2'b01, 1'b0, 1'b1, 1'b0, 8'd3);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    req1_right = 1'b0; req1_left = 1'b1; req2_right = 1'b1;
    frame(); chk_frame("tie_first_p1", 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);
    req1_left = 1'b0;
    frame(); chk_frame("p1_release", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    req1_left = 1'b1;
    frame(); chk_frame("tie_rr_p2", 2'b10, 1'b0, 1'b1, 1'b1, 8'd1);
    req1_left = 1'b0; req2_right = 1'b0;
    frame(); chk_frame("all_release", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    req2_left = 1'b1; req2_right = 1'b1;
    frame(); chk_frame("p2_both_f1", 2'b10, 1'b0, 1'b0, 1'b0, 8'd1);
    frame(); chk_frame("p2_both_f2", 2'b10, 1'b0, 1'b0, 1'b0, 8'd2);
    req2_left = 1'b0; req2_right = 1'b0; req1_right = 1'b1;
    frame(); chk_frame("p2_drop", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    req2_left = 1'b1;
    frame(); chk_frame("contend_f1", 2'b01, 1'b0, 1'b1, 1'b0, 8'd1);
`ifdef PLAYER_ARB_HOLD_LIMIT_EN
    frame(); chk_frame("limit_f2", 2'b01, 1'b0, 1'b1, 1'b0, 8'd2);
    frame(); chk_frame("limit_f3", 2'b01, 1'b0, 1'b1, 1'b0, 8'd3);
    frame(); chk_frame("limit_f4", 2'b01, 1'b0, 1'b1, 1'b0, 8'd4);
    frame(); chk_frame("limit_switch", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    frame(); chk_frame("limit_p2", 2'b10, 1'b1, 1'b0, 1'b1, 8'd1);
`else
    for (int f = 2; f <= 24; f++) begin
      frame();
      chk("keep.grant", 32'(g), 32'd1);
      chk("keep.step_right", 32'(sr), 32'd1);
      chk("keep.hold_cnt", 32'(h), 32'(f));
    end
    repeat (236) frame();
    chk_frame("hold_saturate", 2'b01, 1'b0, 1'b1, 1'b0, 8'd255);
`endif
    req1_right = 1'b0; req2_left = 1'b0;
    frame(); chk_frame("to_idle", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    req1_right = 1'b1;
    pulses = 0;
    @(negedge clk) v_tick = 1'b1;
    repeat (100) @(negedge clk) pulses += int'(step_right);
    v_tick = 1'b0;
    chk("vtick_long.pulses", 32'(pulses), 32'd1);
    chk("vtick_long.grant", 32'(grant), 32'd1);
    chk("vtick_long.hold_cnt", 32'(hold_cnt), 32'd1);
    frame(); chk_frame("vtick_next", 2'b01, 1'b0, 1'b1, 1'b0, 8'd2);
    req1_right = 1'b0; req2_right = 1'b1;
    frame(); chk_frame("p1_off", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    frame(); chk_frame("p2_grant", 2'b10, 1'b0, 1'b1, 1'b1, 8'd1);
    @(negedge clk) req2_right = 1'b0;
    repeat (3) @(negedge clk);
    req2_right = 1'b1;
    frame(); chk_frame("glitch_ignored", 2'b10, 1'b0, 1'b1, 1'b1, 8'd2);
    @(negedge clk) begin rst = 1'b1; v_tick = 1'b1; end
    @(negedge clk);
    chk("rst_edge.grant", 32'(grant), 32'd0);
    chk("rst_edge.steps", 32'({step_left, step_right}), 32'd0);
    chk("rst_edge.hold_cnt", 32'(hold_cnt), 32'd0);
    chk("rst_edge.step_id", 32'(step_id), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_edge.grant", 32'(grant), 32'd2);
    chk("post_rst_edge.step_right", 32'(step_right), 32'd1);
    chk("post_rst_edge.step_id", 32'(step_id), 32'd1);
    chk("post_rst_edge.hold_cnt", 32'(hold_cnt), 32'd1);
    v_tick = 1'b0;
    @(negedge clk);
    chk("post_rst_edge.clear", 32'(step_right), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
